// File: rtl/mjpeg_byte_packer128.sv
// ============================================================================
// mjpeg_byte_packer128
// ----------------------------------------------------------------------------
// Packs the MJPEG encoder byte stream MSB-first into 128-bit words. Words go
// through a small first-word-fall-through FIFO. Each word carries a last-word
// flag and a valid-byte count. The block also reports the byte length and
// rank of each frame for the UDP header.
//
// Ports
//   clk                single clock (camera pixel clock domain)
//   rst                asynchronous, active-high reset
//   i_frame_start      one-cycle pulse, opens a new frame (used only in IDLE)
//   i_mjpeg_de         encoder byte valid
//   i_mjpeg_data[7:0]  encoder byte
//   i_mjpeg_down       one-cycle pulse, encoder finished the frame
//   o_word_valid       FIFO head word valid
//   o_word_data[127:0] head word, first byte of the word in [127:120]
//   o_word_last        head word closes its frame
//   o_word_bytes[4:0]  valid bytes in head word (0..16)
//   i_word_ready       consumer accepts head word
//   o_frame_len        byte count of most recently closed frame
//   o_frame_len_valid  one-cycle pulse when o_frame_len updates
//   o_frame_rank[14:0] rank of current / most recently closed frame
//   o_busy             high in PACK and FLUSH
//   o_overflow         sticky: a full word was dropped because the FIFO was full
// ============================================================================
module mjpeg_byte_packer128 #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_frame_start,
    input  logic               i_mjpeg_de,
    input  logic [7:0]         i_mjpeg_data,
    input  logic               i_mjpeg_down,
    output logic               o_word_valid,
    output logic [127:0]       o_word_data,
    output logic               o_word_last,
    output logic [4:0]         o_word_bytes,
    input  logic               i_word_ready,
    output logic [LEN_W-1:0]   o_frame_len,
    output logic               o_frame_len_valid,
    output logic [14:0]        o_frame_rank,
    output logic               o_busy,
    output logic               o_overflow
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;
    // Each FIFO entry holds {data[127:0], last, bytes[4:0]}.
    localparam int ENTRY_W = 128 + 1 + 5;

    typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

    state_t             state_reg;
    logic [127:0]       shreg_reg;
    logic [3:0]         byte_cnt_reg;
    logic [LEN_W-1:0]   len_cnt_reg;
    logic [14:0]        rank_reg;
    logic               overflow_reg;
    logic [LEN_W-1:0]   frame_len_reg;
    logic               frame_len_valid_reg;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;

    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_pop;
    logic               fifo_room;
    logic               fifo_push;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    logic               byte_take;
    logic               word_done;
    logic               push_full;
    logic               close_push;
    logic [127:0]       full_word;
    logic [127:0]       close_word;
    logic [4:0]         pad_bytes;
    logic [7:0]         shift_bits;

    // ------------------------------------------------------------------
    // FIFO status. The extra pointer bit tells full apart from empty.
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fifo_pop   = !fifo_empty && i_word_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO works then.
    assign fifo_room  = !fifo_full || fifo_pop;

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    assign byte_take  = (state_reg == PACK) && i_mjpeg_de;
    assign word_done  = byte_take && (byte_cnt_reg == 4'd15);
    assign full_word  = {shreg_reg[119:0], i_mjpeg_data};

    // Left-align the partial word. When n = 0, the shift is 128 bits, which
    // gives the all-zero terminator word.
    assign pad_bytes  = 5'd16 - {1'b0, byte_cnt_reg};
    assign shift_bits = {pad_bytes, 3'b000};
    assign close_word = shreg_reg << shift_bits;

    assign push_full  = word_done && fifo_room;
    // The closing word waits in FLUSH until there is room, so it is never lost.
    assign close_push = (state_reg == FLUSH) && fifo_room;
    assign fifo_push  = push_full || close_push;

    always_comb begin
        push_entry = {full_word, 1'b0, 5'd16};
        if (close_push) begin
            push_entry = {close_word, 1'b1, {1'b0, byte_cnt_reg}};
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign head_entry = fifo_mem[rd_ptr_reg[AW-1:0]];

    // The head entry stays fixed until it is popped. It is forced to zero
    // while the FIFO is empty, so that stale or uninitialised storage never
    // reaches the outputs.
    assign o_word_valid = !fifo_empty;
    assign o_word_data  = fifo_empty ? 128'd0 : head_entry[ENTRY_W-1 -: 128];
    assign o_word_last  = fifo_empty ? 1'b0   : head_entry[5];
    assign o_word_bytes = fifo_empty ? 5'd0   : head_entry[4:0];

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= IDLE;
            shreg_reg           <= '0;
            byte_cnt_reg        <= '0;
            len_cnt_reg         <= '0;
            rank_reg            <= '0;
            overflow_reg        <= 1'b0;
            frame_len_reg       <= '0;
            frame_len_valid_reg <= 1'b0;
        end else begin
            frame_len_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_frame_start) begin
                        state_reg    <= PACK;
                        rank_reg     <= rank_reg + 15'd1;
                        byte_cnt_reg <= '0;
                        len_cnt_reg  <= '0;
                        overflow_reg <= 1'b0;
                    end
                end
                PACK: begin
                    if (byte_take) begin
                        shreg_reg    <= full_word;
                        // The 4-bit counter wraps from 15 to 0 on the 16th byte.
                        byte_cnt_reg <= byte_cnt_reg + 4'd1;
                        if (len_cnt_reg != {LEN_W{1'b1}}) begin
                            len_cnt_reg <= len_cnt_reg + {{(LEN_W-1){1'b0}}, 1'b1};
                        end
                        if (word_done && !fifo_room) begin
                            overflow_reg <= 1'b1;
                        end
                    end
                    if (i_mjpeg_down) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (close_push) begin
                        frame_len_reg       <= len_cnt_reg;
                        frame_len_valid_reg <= 1'b1;
                        byte_cnt_reg        <= '0;
                        state_reg           <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_frame_len       = frame_len_reg;
    assign o_frame_len_valid = frame_len_valid_reg;
    assign o_frame_rank      = rank_reg;
    assign o_busy            = (state_reg != IDLE);
    assign o_overflow        = overflow_reg;

endmodule

// File: tb/tb_mjpeg_byte_packer128.sv
module tb_mjpeg_byte_packer128;

    logic         clk;
    logic         rst;
    logic         i_frame_start;
    logic         i_mjpeg_de;
    logic [7:0]   i_mjpeg_data;
    logic         i_mjpeg_down;
    logic         o_word_valid;
    logic [127:0] o_word_data;
    logic         o_word_last;
    logic [4:0]   o_word_bytes;
    logic         i_word_ready;
    logic [23:0]  o_frame_len;
    logic         o_frame_len_valid;
    logic [14:0]  o_frame_rank;
    logic         o_busy;
    logic         o_overflow;

    mjpeg_byte_packer128 #(.FIFO_DEPTH(4), .LEN_W(24)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_frame_start     (i_frame_start),
        .i_mjpeg_de        (i_mjpeg_de),
        .i_mjpeg_data      (i_mjpeg_data),
        .i_mjpeg_down      (i_mjpeg_down),
        .o_word_valid      (o_word_valid),
        .o_word_data       (o_word_data),
        .o_word_last       (o_word_last),
        .o_word_bytes      (o_word_bytes),
        .i_word_ready      (i_word_ready),
        .o_frame_len       (o_frame_len),
        .o_frame_len_valid (o_frame_len_valid),
        .o_frame_rank      (o_frame_rank),
        .o_busy            (o_busy),
        .o_overflow        (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic         last;
        logic [4:0]   bytes;
    } exp_t;

    exp_t         exp_q[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    logic [7:0]   part[16];
    int           m_n;
    int           m_word_idx;
    int           drop_from;
    logic         toggle_ready;
    logic         have_prev;
    logic [127:0] prev_data;
    logic         prev_last;
    logic [4:0]   prev_bytes;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference packing: byte i of a word is placed at bits [127-8i -: 8].
    function automatic logic [127:0] build(input int n);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[127-8*i -: 8] = part[i];
        return w;
    endfunction

    task automatic push_exp(input logic [127:0] d, input logic last, input int nb);
        exp_t e;
        e.d = d; e.last = last; e.bytes = 5'(nb);
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        part[m_n] = b;
        m_n++;
        if (m_n == 16) begin
            if (m_word_idx < drop_from) push_exp(build(16), 1'b0, 16);
            m_word_idx++;
            m_n = 0;
        end
    endtask

    task automatic model_close();
        push_exp(build(m_n), 1'b1, m_n);
        m_n = 0;
    endtask

    // Drives one clock cycle of inputs. Inputs change at posedge+1.
    task automatic cyc(input logic st, input logic de, input logic [7:0] d, input logic dn);
        i_frame_start = st; i_mjpeg_de = de; i_mjpeg_data = d; i_mjpeg_down = dn;
        if (toggle_ready) i_word_ready = ~i_word_ready;
        @(posedge clk); #1;
        i_frame_start = 1'b0; i_mjpeg_de = 1'b0; i_mjpeg_data = 8'h00; i_mjpeg_down = 1'b0;
    endtask

    task automatic start_frame(input int exp_rank, input string tag);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        m_n = 0; m_word_idx = 0; drop_from = 1000;
        chk({tag, "_rank"}, o_frame_rank, exp_rank);
        chk({tag, "_busy"}, o_busy, 1);
    endtask

    task automatic send(input logic [7:0] b, input logic dn);
        cyc(1'b0, 1'b1, b, dn);
        model_byte(b);
        if (dn) model_close();
    endtask

    task automatic close_frame();
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        model_close();
    endtask

    task automatic wait_len(input logic [23:0] exp_len, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (o_frame_len_valid) break;
            @(posedge clk); #1;
        end
        chk({tag, "_len_valid"}, o_frame_len_valid, 1);
        chk({tag, "_len"}, o_frame_len, exp_len);
        chk({tag, "_idle"}, o_busy, 0);
        @(posedge clk); #1;
        chk({tag, "_len_pulse"}, o_frame_len_valid, 0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !o_word_valid) break;
            @(posedge clk); #1;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_fifo_empty"}, o_word_valid, 0);
    endtask

    // Output monitor: it compares accepted words against the scoreboard and
    // checks that a stalled head word stays stable.
    always @(negedge clk) begin
        if (rst || !o_word_valid) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                chk("stall_data", o_word_data, prev_data);
                chk("stall_last", o_word_last, prev_last);
                chk("stall_bytes", o_word_bytes, prev_bytes);
            end
            if (i_word_ready) begin
                have_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("extra_word", o_word_data, 128'hx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", o_word_data, e.d);
                    chk("word_last", o_word_last, e.last);
                    chk("word_bytes", o_word_bytes, e.bytes);
                    $display("word %h last=%0d bytes=%0d", o_word_data, o_word_last, o_word_bytes);
                end
            end else begin
                have_prev  = 1'b1;
                prev_data  = o_word_data;
                prev_last  = o_word_last;
                prev_bytes = o_word_bytes;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_frame_start = 1'b0; i_mjpeg_de = 1'b0; i_mjpeg_data = 8'h00; i_mjpeg_down = 1'b0;
        i_word_ready = 1'b1; toggle_ready = 1'b0;
        m_n = 0; m_word_idx = 0; drop_from = 1000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_word_valid, 0);
        chk("rst_data", o_word_data, 0);
        chk("rst_len", o_frame_len, 0);
        chk("rst_len_valid", o_frame_len_valid, 0);
        chk("rst_rank", o_frame_rank, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_overflow", o_overflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: 32 bytes 00..1F, then down. The words are exactly full, so a terminator follows.
        start_frame(1, "t1");
        for (int i = 0; i < 15; i++) send(8'(i), 1'b0);
        chk("t1_valid_before_word", o_word_valid, 0);
        send(8'd15, 1'b0);
        chk("t1_valid_latency", o_word_valid, 1);
        for (int i = 16; i < 32; i++) send(8'(i), 1'b0);
        close_frame();
        wait_len(24'd32, "t1");
        wait_drain("t1");

        // 2: five bytes, with down in the same cycle as the last byte.
        start_frame(2, "t2");
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
        send(8'hEE, 1'b1);
        wait_len(24'd5, "t2");
        wait_drain("t2");

        // 3: ready low while 80 bytes arrive. Four words fit, the fifth is dropped.
        i_word_ready = 1'b0;
        start_frame(3, "t3");
        drop_from = 4;
        for (int i = 0; i < 64; i++) send(8'(8'h40 + i), 1'b0);
        chk("t3_no_overflow_yet", o_overflow, 0);
        for (int i = 64; i < 80; i++) send(8'(8'h40 + i), 1'b0);
        chk("t3_overflow", o_overflow, 1);
        close_frame();
        repeat (5) begin @(posedge clk); #1; end
        chk("t3_flush_stalled", o_busy, 1);
        chk("t3_no_len_yet", o_frame_len_valid, 0);
        i_word_ready = 1'b1;
        wait_len(24'd80, "t3");
        wait_drain("t3");
        chk("t3_overflow_sticky", o_overflow, 1);

        // 4: ready toggles every cycle on a 48-byte frame.
        start_frame(4, "t4");
        chk("t4_overflow_cleared", o_overflow, 0);
        toggle_ready = 1'b1;
        for (int i = 0; i < 48; i++) send(8'(i * 7 + 3), 1'b0);
        close_frame();
        toggle_ready = 1'b0;
        i_word_ready = 1'b1;
        wait_len(24'd48, "t4");
        wait_drain("t4");

        // 5: reset in the middle of a frame after 7 bytes.
        start_frame(5, "t5");
        for (int i = 0; i < 7; i++) send(8'(8'hC0 + i), 1'b0);
        rst = 1'b1;
        m_n = 0;
        #1;
        chk("t5_rst_busy", o_busy, 0);
        chk("t5_rst_rank", o_frame_rank, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_rst_valid", o_word_valid, 0);
        chk("t5_rst_len", o_frame_len, 0);
        chk("t5_rst_overflow", o_overflow, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("t5_no_last_word", o_word_valid, 0);
        chk("t5_no_len_pulse", o_frame_len_valid, 0);

        // 6: ignored starts, rank sequence, and bytes presented in IDLE.
        start_frame(1, "t6a");
        send(8'h11, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h22, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t6_rank_unchanged", o_frame_rank, 1);
        send(8'h33, 1'b1);
        wait_len(24'd3, "t6a");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h55, 1'b0);
        chk("t6_idle_bytes_ignored", o_busy, 0);
        start_frame(2, "t6b");
        for (int i = 0; i < 20; i++) send(8'(8'h80 + i), 1'b0);
        close_frame();
        wait_len(24'd20, "t6b");
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 8'h66, 1'b0);
        start_frame(3, "t6c");
        send(8'h01, 1'b0); send(8'h02, 1'b1);
        wait_len(24'd2, "t6c");
        wait_drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
